// File: rtl/fetch_mem_arbiter_pkg.sv
// Shared types and default widths for the fetch/data memory arbiter.
package fetch_mem_arbiter_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

  typedef enum logic {
    GNT_IF,
    GNT_DM
  } arb_gnt_t;
endpackage

// File: rtl/fetch_mem_arbiter_starve.sv
// Saturating count of consecutive data grants made while fetch is waiting.
module arb_starve_counter #(
  parameter int MAX   = 4,
  parameter int CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);
  assign at_max = (count == CNT_W'(MAX));

  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && !at_max)
      count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/fetch_mem_arbiter.sv
// Shares one synchronous-read memory between the fetch port and the data port,
// one transaction at a time, data first with a bounded fetch starvation.
//
// state    | meaning
// ST_IDLE  | sample requests, latch the winner
// ST_ISSUE | mem_en strobe for the latched transaction
// ST_WAIT  | MEM_LAT cycles, capture mem_rdata on the last one
// ST_RESP  | one-cycle valid pulse to the granted port
module fetch_mem_arbiter #(
  parameter int ADDR_W     = fetch_mem_arbiter_pkg::ADDR_W,
  parameter int DATA_W     = fetch_mem_arbiter_pkg::DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import fetch_mem_arbiter_pkg::*;

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int LAT_W = 2;

  arb_state_t       state, state_nxt;
  arb_gnt_t         gnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_at_max;
  logic             starve_clr;
  logic             starve_inc;
  logic             grant;
  logic             pick_if;
  logic             lat_done;

  assign pick_if  = if_req && (!dm_req || starve_at_max);
  assign lat_done = (lat_cnt == '0);
  assign if_stall = if_req && !if_valid;

  arb_starve_counter #(
    .MAX   (STARVE_MAX),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .clr    (starve_clr),
    .inc    (starve_inc),
    .count  (starve_cnt),
    .at_max (starve_at_max)
  );

  always_ff @(posedge clk) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    starve_clr = 1'b0;
    starve_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          grant     = 1'b1;
          state_nxt = ST_ISSUE;
          // Only a data grant that overtakes a waiting fetch counts.
          if (pick_if || !if_req)
            starve_clr = 1'b1;
          else
            starve_inc = 1'b1;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (lat_done) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt       <= GNT_IF;
      lat_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      mem_en   <= grant;
      mem_we   <= grant && !pick_if && dm_we;
      if_valid <= (state == ST_WAIT) && lat_done && (gnt == GNT_IF);
      dm_valid <= (state == ST_WAIT) && lat_done && (gnt == GNT_DM);

      // mem_addr/mem_wdata double as the latched request for the whole transaction.
      if (grant) begin
        gnt       <= pick_if ? GNT_IF : GNT_DM;
        mem_addr  <= pick_if ? if_addr : dm_addr;
        mem_wdata <= pick_if ? '0 : dm_wdata;
      end

      if (state == ST_ISSUE)
        lat_cnt <= LAT_W'(MEM_LAT - 1);
      else if (state == ST_WAIT && !lat_done)
        lat_cnt <= lat_cnt - LAT_W'(1);

      if (state == ST_WAIT && lat_done) begin
        if (gnt == GNT_IF)
          if_rdata <= mem_rdata;
        else
          dm_rdata <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: transaction-level timing/memory model plus directed scenarios.
module tb_fetch_mem_arbiter;
  localparam int AW   = 10;
  localparam int DW   = 10;
  localparam int SMAX = 4;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic          if_valid, if_stall, dm_valid, mem_en, mem_we;

  logic          if_req3, dm_req3, dm_we3;
  logic [AW-1:0] if_addr3, dm_addr3, mem_addr3;
  logic [DW-1:0] dm_wdata3, if_rdata3, dm_rdata3, mem_wdata3, mem_rdata3;
  logic          if_valid3, if_stall3, dm_valid3, mem_en3, mem_we3;

  fetch_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  fetch_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(SMAX)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_valid(if_valid3), .if_stall(if_stall3),
    .dm_req(dm_req3), .dm_we(dm_we3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
    .dm_rdata(dm_rdata3), .dm_valid(dm_valid3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'((i * 389 + 101) ^ (i >> 3));
  endfunction

  // Memory devices: synchronous read with 1 and 3 cycles of latency.
  logic          fill, pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] ram1 [0:1023];
  logic [DW-1:0] ram3 [0:1023];
  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe3 [0:2];

  assign mem_rdata  = pipe1;
  assign mem_rdata3 = pipe3[2];

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 1024; i++) begin
        ram1[i] <= init_word(i);
        ram3[i] <= init_word(i);
      end
    end else if (pre_en) begin
      ram1[pre_addr] <= pre_data;
      ram3[pre_addr] <= pre_data;
    end else begin
      if (mem_en && mem_we) ram1[mem_addr] <= mem_wdata;
      if (mem_en3 && mem_we3) ram3[mem_addr3] <= mem_wdata3;
    end
    pipe1    <= mem_en ? ram1[mem_addr] : DW'($urandom);
    pipe3[0] <= mem_en3 ? ram3[mem_addr3] : DW'($urandom);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model state: arbiter free time, scheduled issue/valid cycles, starvation count.
  bit            chk_on = 1'b0;
  int            m_free, m_issue = -1, m_valid = -1, m_starve = 0;
  bit            m_if, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [DW-1:0] ref_mem [0:1023];

  bit            if_done, dm_done, dm3_done;
  int            ev_if_cyc, ev_dm_cyc, ev3_dm_cyc, n_if_pulses = 0;
  logic [DW-1:0] ev_if_data, ev_dm_data, ev3_dm_data;
  int            issue_cyc_q[$];
  logic [AW-1:0] issue_addr_q[$];
  bit            issue_we_q[$];
  int            issue3_q[$];

  task automatic model_step();
    bit issue_now, valid_now, win_if;
    issue_now = (cyc == m_issue);
    valid_now = (cyc == m_valid);
    if (chk_on) begin
      check("mem_en", 32'(mem_en), 32'(issue_now));
      check("mem_we", 32'(mem_we), 32'(issue_now && m_we));
      if (issue_now) begin
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_we) check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      end
      check("if_valid", 32'(if_valid), 32'(valid_now && m_if));
      check("dm_valid", 32'(dm_valid), 32'(valid_now && !m_if));
      if (valid_now && !m_we) begin
        if (m_if) check("if_rdata", 32'(if_rdata), 32'(m_rdata));
        else      check("dm_rdata", 32'(dm_rdata), 32'(m_rdata));
      end
      check("if_stall", 32'(if_stall), 32'(if_req && !(valid_now && m_if)));
    end

    if_done  = (if_valid === 1'b1);
    dm_done  = (dm_valid === 1'b1);
    dm3_done = (dm_valid3 === 1'b1);
    if (if_done) begin ev_if_cyc = cyc; ev_if_data = if_rdata; n_if_pulses++; end
    if (dm_done) begin ev_dm_cyc = cyc; ev_dm_data = dm_rdata; end
    if (dm3_done) begin ev3_dm_cyc = cyc; ev3_dm_data = dm_rdata3; end
    if (mem_en === 1'b1) begin
      issue_cyc_q.push_back(cyc);
      issue_addr_q.push_back(mem_addr);
      issue_we_q.push_back(mem_we);
    end
    if (mem_en3 === 1'b1) issue3_q.push_back(cyc);

    if (!reset) begin
      m_issue  = -1;
      m_valid  = -1;
      m_free   = cyc + 1;
      m_starve = 0;
    end else if (cyc >= m_free && (if_req || dm_req)) begin
      win_if = if_req && (!dm_req || m_starve == SMAX);
      if (win_if || !if_req) m_starve = 0;
      else if (m_starve < SMAX) m_starve = m_starve + 1;
      m_if    = win_if;
      m_addr  = win_if ? if_addr : dm_addr;
      m_we    = !win_if && dm_we;
      m_wdata = dm_wdata;
      m_issue = cyc + 1;
      m_valid = cyc + 2 + LAT1;
      m_free  = cyc + 3 + LAT1;
      if (m_we) ref_mem[m_addr] = m_wdata;
      else      m_rdata = ref_mem[m_addr];
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    cycle();
    pre_en = 1'b0;
  endtask

  // Step until both ports are idle; a port drops its request after its valid,
  // except data re-requests while dm_refill is set and fetch is still waiting.
  task automatic run_txn(input int budget, input bit dm_refill);
    int n;
    n = 0;
    while ((if_req || dm_req) && n < budget) begin
      cycle();
      n++;
      if (if_req && if_done) if_req = 1'b0;
      if (dm_req && dm_done) begin
        if (dm_refill && if_req) dm_addr = dm_addr + AW'(1);
        else dm_req = 1'b0;
      end
    end
    check("txn_timeout", 32'(if_req || dm_req), 0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return AW'('h3FF);
      1, 2:    return AW'($urandom_range(0, 15));
      default: return AW'($urandom);
    endcase
  endfunction

  initial begin
    int start, n, pulses_before;
    reset = 1'b0; fill = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    if_req3 = 0; if_addr3 = '0; dm_req3 = 0; dm_we3 = 0; dm_addr3 = '0; dm_wdata3 = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    cycle();
    chk_on = 1'b1;
    cycle();
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_if_valid", 32'(if_valid), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    fill = 1'b0;
    reset = 1'b1;
    cycle();

    // Fetch-only read
    preload(AW'('h040), DW'('h155));
    issue_cyc_q.delete(); issue_addr_q.delete(); issue_we_q.delete();
    if_req = 1; if_addr = AW'('h040); start = cyc;
    run_txn(20, 0);
    check("t1_n_issue", issue_cyc_q.size(), 1);
    if (issue_cyc_q.size() >= 1) begin
      check("t1_issue_cyc", 32'(issue_cyc_q[0] - start), 1);
      check("t1_issue_addr", 32'(issue_addr_q[0]), 'h040);
    end
    check("t1_valid_cyc", 32'(ev_if_cyc - start), 3);
    check("t1_rdata", 32'(ev_if_data), 'h155);

    // Simultaneous requests: data first
    issue_cyc_q.delete(); issue_addr_q.delete(); issue_we_q.delete();
    dm_req = 1; dm_we = 0; dm_addr = AW'('h010); if_req = 1; if_addr = AW'('h020); start = cyc;
    run_txn(30, 0);
    check("t2_dm_valid_cyc", 32'(ev_dm_cyc - start), 3);
    check("t2_n_issue", issue_cyc_q.size(), 2);
    if (issue_cyc_q.size() >= 2) begin
      check("t2_if_issue_cyc", 32'(issue_cyc_q[1] - start), 5);
      check("t2_if_issue_addr", 32'(issue_addr_q[1]), 'h020);
    end
    check("t2_if_valid_cyc", 32'(ev_if_cyc - start), 7);

    // Starvation bound: four data grants, then fetch
    issue_cyc_q.delete(); issue_addr_q.delete(); issue_we_q.delete();
    dm_req = 1; dm_we = 0; dm_addr = AW'('h100); if_req = 1; if_addr = AW'('h200); start = cyc;
    run_txn(60, 1);
    check("t3_n_issue", issue_cyc_q.size(), 6);
    if (issue_cyc_q.size() >= 5) begin
      for (int k = 0; k < 5; k++)
        check("t3_issue_cyc", 32'(issue_cyc_q[k] - start), 32'(1 + 4 * k));
      check("t3_dm4_addr", 32'(issue_addr_q[3]), 'h103);
      check("t3_if_addr", 32'(issue_addr_q[4]), 'h200);
    end
    check("t3_starve_cnt", 32'(dut1.starve_cnt), 0);

    // Write 0x3FF then read it back
    issue_cyc_q.delete(); issue_addr_q.delete(); issue_we_q.delete();
    dm_req = 1; dm_we = 1; dm_addr = AW'('h3FF); dm_wdata = DW'('h2AA); start = cyc;
    run_txn(20, 0);
    check("t4_n_issue", issue_cyc_q.size(), 1);
    if (issue_cyc_q.size() >= 1) begin
      check("t4_we", 32'(issue_we_q[0]), 1);
      check("t4_addr", 32'(issue_addr_q[0]), 'h3FF);
    end
    check("t4_valid_cyc", 32'(ev_dm_cyc - start), 3);
    dm_req = 1; dm_we = 0; dm_addr = AW'('h3FF); dm_wdata = '0;
    run_txn(20, 0);
    check("t4_readback", 32'(ev_dm_data), 'h2AA);

    // Randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      if (if_req) begin
        if (if_done) begin if_req = ($urandom_range(0, 1) == 1); if_addr = rand_addr(); end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = rand_addr();
      end
      if (dm_req) begin
        if (dm_done) begin
          dm_req = ($urandom_range(0, 3) != 0); dm_addr = rand_addr();
          dm_we = ($urandom_range(0, 2) == 0); dm_wdata = DW'($urandom);
        end
      end else if ($urandom_range(0, 3) != 0) begin
        dm_req = 1; dm_addr = rand_addr();
        dm_we = ($urandom_range(0, 2) == 0); dm_wdata = DW'($urandom);
      end
      cycle();
    end
    run_txn(60, 0);

    // Reset during WAIT of a fetch read
    if_req = 1; if_addr = AW'('h050); dm_we = 0;
    cycle();
    cycle();
    reset = 1'b0;
    pulses_before = n_if_pulses;
    cycle();
    reset = 1'b1; if_req = 0;
    check("t5_mem_en", 32'(mem_en), 0);
    check("t5_mem_we", 32'(mem_we), 0);
    check("t5_if_valid", 32'(if_valid), 0);
    check("t5_dm_valid", 32'(dm_valid), 0);
    check("t5_if_rdata", 32'(if_rdata), 0);
    check("t5_dm_rdata", 32'(dm_rdata), 0);
    check("t5_mem_addr", 32'(mem_addr), 0);
    check("t5_mem_wdata", 32'(mem_wdata), 0);
    for (int k = 0; k < 6; k++) cycle();
    check("t5_no_pulse", 32'(n_if_pulses - pulses_before), 0);
    if_req = 1; if_addr = AW'('h051); start = cyc;
    run_txn(20, 0);
    check("t5_after_pulse", 32'(n_if_pulses - pulses_before), 1);
    check("t5_after_cyc", 32'(ev_if_cyc - start), 3);

    // MEM_LAT=3 instance, two back-to-back data reads
    preload(AW'('h007), DW'('h0AB));
    issue3_q.delete();
    dm_req3 = 1; dm_we3 = 0; dm_addr3 = AW'('h007); start = cyc;
    n = 0;
    while (!dm3_done && n < 20) begin cycle(); n++; end
    check("t6_first_done", 32'(dm3_done), 1);
    check("t6_valid_cyc", 32'(ev3_dm_cyc - start), 5);
    check("t6_rdata", 32'(ev3_dm_data), 'h0AB);
    dm_addr3 = AW'('h008);
    n = 0;
    do begin cycle(); n++; end while (!dm3_done && n < 20);
    dm_req3 = 0;
    check("t6_second_done", 32'(dm3_done), 1);
    check("t6_second_rdata", 32'(ev3_dm_data), 32'(init_word(8)));
    check("t6_n_issue", issue3_q.size(), 2);
    if (issue3_q.size() >= 2) begin
      check("t6_issue0_cyc", 32'(issue3_q[0] - start), 1);
      check("t6_issue1_cyc", 32'(issue3_q[1] - start), 7);
    end
    check("t6_if_stall", 32'(if_stall3), 0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
